// File: rtl/trace_stream_tx_if.sv
// TRACE AXI-Stream bundle: 128-bit payload with tlast and a valid/ready handshake.
// The master is the transmitter (trace_stream_tx); the slave is the downstream consumer.
interface trace_stream_tx_if;
   logic         TRACE_tvalid;
   logic         TRACE_tready;
   logic [127:0] TRACE_tdata;
   logic         TRACE_tlast;

   modport master (
      output TRACE_tvalid,
      output TRACE_tdata,
      output TRACE_tlast,
      input  TRACE_tready
   );

   modport slave (
      input  TRACE_tvalid,
      input  TRACE_tdata,
      input  TRACE_tlast,
      output TRACE_tready
   );
endinterface

// File: rtl/trace_stream_tx.sv
// TRACE stream transmitter: captures one writeback retirement record per cycle,
// buffers it in a FIFO and emits it as one 128-bit AXI-Stream beat.
// Occupancy counts the FIFO entries plus the output register, so full means
// DEPTH records held in total. Records offered while full are dropped and counted.
module trace_stream_tx #(
   parameter int DEPTH   = 16,
   parameter int PKT_LEN = 256,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,            // asynchronous, active low
   input  logic                 w_valid,
   input  logic                 w_enable,
   input  logic [4:0]           w_destination,
   input  logic [31:0]          w_data,
   input  logic [31:0]          w_pc,
   input  logic                 w_last,
   output logic                 w_ready,
   trace_stream_tx_if.master    trace,
   output logic                 overflow,
   output logic [CNT_W-1:0]     drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam int EW = 71;   // 70 payload bits + halt flag

   // Storage and pointers
   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_mem_cnt;

   // Output register and packet state
   logic             r_tvalid;
   logic [127:0]     r_tdata;
   logic             r_tlast;
   logic [BW-1:0]    r_beat_cnt;

   // Drop tracking
   logic             r_overflow;
   logic [CNT_W-1:0] r_drop_cnt;

   logic [CW-1:0]    w_occupancy;
   logic             w_full;
   logic             w_push;
   logic             w_drop;
   logic             w_pop_out;
   logic             w_load;
   logic [BW-1:0]    w_beat_next;
   logic [EW-1:0]    w_rd_entry;
   logic             w_load_last;

   assign w_occupancy = r_mem_cnt + CW'(r_tvalid);
   assign w_full      = (w_occupancy == CW'(DEPTH));
   assign w_push      = w_valid & ~w_full;
   assign w_drop      = w_valid & w_full;
   assign w_pop_out   = r_tvalid & trace.TRACE_tready;
   // Refill the output register when it is empty or being consumed this cycle.
   assign w_load      = (r_mem_cnt != '0) & (~r_tvalid | trace.TRACE_tready);
   assign w_rd_entry  = r_mem[r_rd_ptr];

   // Beat index the next loaded beat will carry: accounts for a handshake this cycle.
   assign w_beat_next = w_pop_out ? (r_tlast ? '0 : r_beat_cnt + 1'b1) : r_beat_cnt;
   assign w_load_last = w_rd_entry[70] | (w_beat_next == BW'(PKT_LEN - 1));

   assign w_ready            = ~w_full;
   assign trace.TRACE_tvalid = r_tvalid;
   assign trace.TRACE_tdata  = r_tdata;
   assign trace.TRACE_tlast  = r_tlast;
   assign overflow           = r_overflow;
   assign drop_count         = r_drop_cnt;

   // Record storage: plain array without reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_last, w_enable, w_destination, w_data, w_pc};
      end
   end

   // FIFO pointers and entry count (output register tracked separately).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_mem_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_mem_cnt <= r_mem_cnt + CW'(w_push) - CW'(w_load);
      end
   end

   // Output register: holds tdata/tlast stable until the handshake completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tvalid   <= 1'b0;
         r_tdata    <= '0;
         r_tlast    <= 1'b0;
         r_beat_cnt <= '0;
      end else begin
         r_beat_cnt <= w_beat_next;
         if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= {58'd0, w_rd_entry[69:0]};
            r_tlast  <= w_load_last;
         end else if (w_pop_out) begin
            r_tvalid <= 1'b0;
         end
      end
   end

   // Sticky overflow flag and saturating dropped-record counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_trace_stream_tx.sv
// Bench for trace_stream_tx: two instances (PKT_LEN 256 and 4) share the same
// record and tready stimulus; each has its own expected-beat queue and monitor.
module tb_trace_stream_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        w_valid = 1'b0;
   logic        w_enable = 1'b0;
   logic        w_last = 1'b0;
   logic [4:0]  w_destination = '0;
   logic [31:0] w_data = '0;
   logic [31:0] w_pc = '0;
   logic        tready = 1'b0;

   logic        w_ready_a, w_ready_b, ovf_a, ovf_b;
   logic [15:0] drop_a, drop_b;

   always #5 clk = ~clk;

   trace_stream_tx_if ifa();
   trace_stream_tx_if ifb();
   assign ifa.TRACE_tready = tready;
   assign ifb.TRACE_tready = tready;

   trace_stream_tx #(.DEPTH(16), .PKT_LEN(256), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .w_valid(w_valid), .w_enable(w_enable),
      .w_destination(w_destination), .w_data(w_data), .w_pc(w_pc), .w_last(w_last),
      .w_ready(w_ready_a), .trace(ifa), .overflow(ovf_a), .drop_count(drop_a)
   );

   trace_stream_tx #(.DEPTH(16), .PKT_LEN(4), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .w_valid(w_valid), .w_enable(w_enable),
      .w_destination(w_destination), .w_data(w_data), .w_pc(w_pc), .w_last(w_last),
      .w_ready(w_ready_b), .trace(ifb), .overflow(ovf_b), .drop_count(drop_b)
   );

   int checks = 0;
   int errors = 0;
   int hs_a = 0;
   int bc_a = 0;
   int bc_b = 0;
   logic [128:0] exp_a[$];
   logic [128:0] exp_b[$];

   logic         prev_v[2];
   logic         prev_hs[2];
   logic [128:0] prev_d[2];

   task automatic check(input string name, input logic [128:0] act, input logic [128:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Queue the beat an accepted record must produce on each instance.
   task automatic expect_rec(input logic [31:0] pc, input logic [31:0] data,
                             input logic [4:0] dest, input logic en, input logic last);
      logic [127:0] d;
      logic ta, tb;
      d  = {58'd0, en, dest, data, pc};
      ta = last || (bc_a == 255);
      tb = last || (bc_b == 3);
      bc_a = ta ? 0 : bc_a + 1;
      bc_b = tb ? 0 : bc_b + 1;
      exp_a.push_back({ta, d});
      exp_b.push_back({tb, d});
   endtask

   // Called at posedge+1: offers one record for one cycle.
   task automatic push_rec(input logic [31:0] pc, input logic [31:0] data,
                           input logic [4:0] dest, input logic en, input logic last,
                           input logic accept);
      check("w_ready", {128'd0, w_ready_a}, {128'd0, accept});
      w_valid = 1'b1; w_pc = pc; w_data = data; w_destination = dest;
      w_enable = en; w_last = last;
      if (accept) expect_rec(pc, data, dest, en, last);
      @(posedge clk); #1;
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain", 129'(exp_a.size() + exp_b.size()), 129'd0);
   endtask

   // One monitor step for instance k: stability rules then scoreboard pop.
   task automatic mon(input int k, input logic v, input logic [128:0] d);
      logic [128:0] e;
      logic have;
      have = 1'b0;
      e = '0;
      if (prev_v[k] && !prev_hs[k]) begin
         check(k == 0 ? "hold_valid_a" : "hold_valid_b", {128'd0, v}, 129'd1);
         check(k == 0 ? "hold_data_a" : "hold_data_b", d, prev_d[k]);
      end
      if (v && tready) begin
         if (k == 0 && exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
         if (k == 1 && exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
         if (!have) begin
            checks++;
            errors++;
            $display("FAIL beat_unexpected dut%0d: got %h, expected no beat", k, d);
         end else begin
            check(k == 0 ? "beat_a" : "beat_b", d, e);
         end
         if (k == 0) begin
            hs_a++;
            $display("beat %0d: pc=%h data=%h tlast=%b", hs_a, d[31:0], d[63:32], d[128]);
         end
      end
      prev_v[k]  = v;
      prev_hs[k] = v && tready;
      prev_d[k]  = d;
   endtask

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            prev_v[k] = 1'b0; prev_hs[k] = 1'b0; prev_d[k] = '0;
         end
      end else begin
         mon(0, ifa.TRACE_tvalid, {ifa.TRACE_tlast, ifa.TRACE_tdata});
         mon(1, ifb.TRACE_tvalid, {ifb.TRACE_tlast, ifb.TRACE_tdata});
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pushed;
      int cyc;
      for (int k = 0; k < 2; k++) begin
         prev_v[k] = 1'b0; prev_hs[k] = 1'b0; prev_d[k] = '0;
      end

      // Reset state
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tvalid", {128'd0, ifa.TRACE_tvalid}, 129'd0);
      check("rst_tdata", {1'b0, ifa.TRACE_tdata}, 129'd0);
      check("rst_tlast", {128'd0, ifb.TRACE_tlast}, 129'd0);
      check("rst_overflow", {128'd0, ovf_a}, 129'd0);
      check("rst_drop", {113'd0, drop_a}, 129'd0);
      check("rst_w_ready", {128'd0, w_ready_b}, 129'd1);
      rst = 1'b1;
      @(posedge clk); #1;

      // Streaming: 10 back-to-back records, one beat per cycle
      tready = 1'b1;
      begin
         int s;
         s = hs_a;
         for (int i = 0; i < 10; i++)
            push_rec(32'h00100000 + 32'(4 * i), 32'h11111111 * 32'(i), 5'(i), 1'b1, 1'b0, 1'b1);
         repeat (2) @(posedge clk);
         #1;
         check("stream_throughput", 129'(hs_a - s), 129'd10);
         check("stream_drop", {113'd0, drop_a}, 129'd0);
      end
      wait_drain();

      // Single record: latency and payload layout
      push_rec(32'h01000000, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b1);
      check("latency_edge_n", {128'd0, ifa.TRACE_tvalid}, 129'd0);
      @(posedge clk); #1;
      check("latency_edge_n1", {128'd0, ifa.TRACE_tvalid}, 129'd1);
      check("single_tdata", {1'b0, ifa.TRACE_tdata},
            {59'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h01000000});
      check("single_tlast", {128'd0, ifa.TRACE_tlast}, 129'd0);
      @(posedge clk); #1;
      check("empty_tvalid", {128'd0, ifa.TRACE_tvalid}, 129'd0);
      check("empty_tdata_hold", {1'b0, ifa.TRACE_tdata},
            {59'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h01000000});

      // Backpressure: fill 16, 17th dropped, drop again on push+pop while full
      tready = 1'b0;
      for (int i = 0; i < 16; i++)
         push_rec(32'h01000000 + 32'(4 * i), 32'hA0000000 + 32'(i), 5'(i), 1'(i), 1'b0, 1'b1);
      push_rec(32'h02000000, 32'hBAD0BAD0, 5'd31, 1'b1, 1'b0, 1'b0);
      check("bp_overflow", {128'd0, ovf_a}, 129'd1);
      check("bp_drop1", {113'd0, drop_a}, 129'd1);
      repeat (3) @(posedge clk);
      #1;
      tready = 1'b1;
      push_rec(32'h02000004, 32'hBAD1BAD1, 5'd30, 1'b1, 1'b0, 1'b0);
      check("bp_drop2", {113'd0, drop_b}, 129'd2);
      check("bp_ready_after_pop", {128'd0, w_ready_a}, 129'd1);
      wait_drain();

      // Reset pulse with records queued and tvalid high
      tready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_rec(32'h03000000 + 32'(4 * i), 32'(i), 5'(i), 1'b1, 1'b0, 1'b1);
      check("pre_rst_tvalid", {128'd0, ifb.TRACE_tvalid}, 129'd1);
      #3 rst = 1'b0;
      #1;
      check("async_rst_tvalid_a", {128'd0, ifa.TRACE_tvalid}, 129'd0);
      check("async_rst_tvalid_b", {128'd0, ifb.TRACE_tvalid}, 129'd0);
      check("async_rst_w_ready", {128'd0, w_ready_a}, 129'd1);
      check("async_rst_drop", {113'd0, drop_b}, 129'd0);
      check("async_rst_overflow", {128'd0, ovf_b}, 129'd0);
      exp_a.delete();
      exp_b.delete();
      bc_a = 0;
      bc_b = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // After reset: beat 0 has tlast=0; halt flag on the third record
      tready = 1'b1;
      push_rec(32'h04000000, 32'h0000AAAA, 5'd1, 1'b1, 1'b0, 1'b1);
      push_rec(32'h04000004, 32'h0000BBBB, 5'd2, 1'b0, 1'b0, 1'b1);
      push_rec(32'h04000008, 32'h0000CCCC, 5'd3, 1'b1, 1'b1, 1'b1);
      // Next packet of 256: tlast only on its 256th beat for the default instance
      for (int i = 0; i < 256; i++)
         push_rec(32'h05000000 + 32'(4 * i), ~32'(i), 5'(i), 1'(i >> 1), 1'b0, 1'b1);
      wait_drain();

      // Random tready, 1000 pushes gated by w_ready
      pushed = 0;
      cyc = 0;
      while (pushed < 1000 && cyc < 20000) begin
         tready = 1'($urandom_range(0, 1));
         if (w_ready_a) begin
            w_valid = 1'b1;
            w_pc = $urandom;
            w_data = $urandom;
            w_destination = 5'($urandom_range(0, 31));
            w_enable = 1'($urandom_range(0, 1));
            w_last = 1'b0;
            expect_rec(w_pc, w_data, w_destination, w_enable, 1'b0);
            pushed++;
         end else begin
            w_valid = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      w_valid = 1'b0;
      check("rand_pushes", 129'(pushed), 129'd1000);
      check("rand_drop", {113'd0, drop_a}, 129'd0);
      check("rand_overflow", {128'd0, ovf_a}, 129'd0);
      tready = 1'b1;
      wait_drain();
      repeat (2) @(posedge clk);
      #1;
      check("final_tvalid", {128'd0, ifa.TRACE_tvalid}, 129'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trace_stream_tx.md
Name: trace_stream_tx

Overview:
- Transmitter end of the 128-bit TRACE AXI-Stream: captures one writeback-stage retirement record per cycle from the core and emits it as one stream beat.
- Decouples the core from downstream backpressure with a FIFO. Reports full status so the core can stall, and counts dropped records.
- Sits in the overlay top between the pipeline W stage and the TRACE_t* top-level ports.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2).
- PKT_LEN, 256, beats per packet before tlast is forced (≥1).
- CNT_W, 16, width of the dropped-record counter.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous, active-low reset.
- w_valid  input  1  retirement record present this cycle.
- w_enable  input  1  register write enable of the retired instruction.
- w_destination  input  5  destination register index.
- w_data  input  32  writeback data.
- w_pc  input  32  PC of the retired instruction.
- w_last  input  1  record is the final one of the program (halt); forces tlast.
- w_ready  output  1  FIFO not full; a record is accepted only when w_valid & w_ready.
- TRACE_tvalid  output  1  beat valid.
- TRACE_tready  input  1  consumer ready.
- TRACE_tdata  output  128  beat payload.
- TRACE_tlast  output  1  last beat of packet.
- overflow  output  1  sticky; set when any record is dropped.
- drop_count  output  CNT_W  records dropped; saturating.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, TRACE_tvalid=0, TRACE_tdata=0, TRACE_tlast=0, overflow=0, drop_count=0, beat counter=0, w_ready=1.
- Payload layout:
  - tdata[31:0] = w_pc
  - tdata[63:32] = w_data
  - tdata[68:64] = w_destination
  - tdata[69] = w_enable
  - tdata[127:70] = 0
- Each FIFO entry stores 71 bits: the 70 payload bits plus w_last.
- Push: occurs when w_valid & w_ready.
- w_ready = !full. It is a function of FIFO occupancy only and is never combinationally dependent on TRACE_tready.
- Drop: when w_valid & !w_ready, the record is discarded, overflow is set, and drop_count increments, saturating at 2^CNT_W-1.
- Output stage: registered, AXI-Stream compliant.
  - Once TRACE_tvalid=1, tdata and tlast stay stable until TRACE_tvalid & TRACE_tready.
  - tvalid never deasserts without a handshake.
- Latency: a record pushed into an empty FIFO at edge N drives TRACE_tvalid=1 after edge N+1 (one cycle). No combinational path from w_* to TRACE_*.
- Throughput: with TRACE_tready held at 1, sustain 1 beat/cycle indefinitely with no drops.
- Occupancy: count includes the output register. Full means DEPTH records are held.
- Simultaneous push and pop while full: the pop frees a slot only on the following cycle. w_ready stays 0 in that cycle and the incoming record is dropped. The core is required to honour w_ready.
- tlast is computed at pop-into-output-register time. It is 1 if the stored w_last=1 or the beat counter = PKT_LEN-1.
- Beat counter:
  - Increments on each output handshake.
  - Clears to 0 after a handshake whose tlast=1.
  - Wraps only through this clear.
- PKT_LEN=1: every beat has tlast=1.
- Empty FIFO with tready=1: tvalid=0, and tdata holds its last value (don't-care to the consumer).
- Reset asserted mid-packet: all records are lost and tvalid drops immediately (asynchronous). The next packet starts with beat counter 0.
- overflow and drop_count clear only on reset.

Test Plan:
- Single record: w_pc=0x01000000, w_data=0xDEADBEEF, dest=5, en=1, tready=1 → after one cycle tvalid=1, tdata[69:0]={1,5'd5,0xDEADBEEF,0x01000000}, tdata[127:70]=0, tlast=0 (PKT_LEN=256).
- Backpressure:
  - Stimulus: tready=0, push 16 records (pc 0x01000000+4i); then a 17th.
  - Required: w_ready=0 after the 16th; the 17th is dropped, overflow=1, drop_count=1.
  - Then tready=1: 16 beats in PC order with tdata stable across the stall.
- Streaming: PKT_LEN=4, continuous pushes with tready=1, 10 records → one beat/cycle, tlast on beats 3 and 7, 0 elsewhere, no drops.
- Halt: w_last=1 on the 3rd record with PKT_LEN=256 → tlast=1 on beat 2. The next record's packet restarts, giving tlast on its 256th beat.
- Random tready (50%) with 1000 pushes gated by w_ready → scoreboard matches in order, drop_count=0, tvalid never drops without a handshake.
- Reset pulse with 5 records queued and tvalid=1 → tvalid=0 immediately, w_ready=1, counters 0; a following single push emits with tlast=0.
